// File: rtl/cpu_loader_pkg.sv
// Shared opcodes, command field positions and FSM states for the CPU program loader.
package cpu_loader_pkg;

  typedef enum logic [1:0] {
    OP_LOAD_I = 2'b00,
    OP_LOAD_D = 2'b01,
    OP_RUN    = 2'b10,
    OP_HALT   = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    RUN
  } state_e;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 30;
  localparam int CNT_HI  = 25;
  localparam int CNT_LO  = 16;
  localparam int BASE_LO = 0;
  localparam int CNT_W   = CNT_HI - CNT_LO + 1;

  function automatic opcode_e decode_op(input logic [31:0] word);
    return opcode_e'(word[OP_HI:OP_LO]);
  endfunction

endpackage

// File: rtl/loader_run_timer.sv
// Run budget latch and cycle counter; flags the cycle on which a bounded run ends.
module loader_run_timer
  import cpu_loader_pkg::*;
#(
  parameter int RUN_CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 run_en,
  input  logic [RUN_CNT_W-1:0] budget,
  output logic                 expire
);

  logic [RUN_CNT_W-1:0] budget_q;
  logic [RUN_CNT_W-1:0] cnt_q;
  logic [RUN_CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt_q + RUN_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      budget_q <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      budget_q <= budget;
      cnt_q    <= '0;
    end else if (run_en) begin
      cnt_q <= cnt_nxt;
    end
  end

  // A zero budget never matches, so the run continues until HALT.
  assign expire = run_en && (budget_q != '0) && (cnt_nxt == budget_q);

endmodule

// File: rtl/cpu_program_loader.sv
// Host-side sequencer: loads CPU instruction/data memory from a command stream, then runs it.
module cpu_program_loader
  import cpu_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int WR_HOLD   = 1,
  parameter int RUN_CNT_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              cpu_rst,
  output logic [ADDR_W-1:0] cpu_address,
  output logic [DATA_W-1:0] cpu_inst_data,
  output logic              cpu_write_instruction,
  output logic              cpu_write_data,
  output logic              done,
  output logic              err
);

  localparam int HOLD_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;

  state_e state_q, state_d;

  logic              s_ready_q, s_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [ADDR_W-1:0] cpu_address_q, cpu_address_d;
  logic [DATA_W-1:0] cpu_inst_data_q, cpu_inst_data_d;
  logic              wr_i_q, wr_i_d;
  logic              wr_d_q, wr_d_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              tgt_data_q, tgt_data_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic             accept;
  opcode_e          op;
  logic [CNT_W-1:0] cmd_cnt;
  logic             timer_start;
  logic             timer_expire;

  assign accept  = s_valid && s_ready_q;
  assign op      = decode_op(s_data[31:0]);
  assign cmd_cnt = s_data[CNT_HI:CNT_LO];

  loader_run_timer #(
    .RUN_CNT_W(RUN_CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (timer_start),
    .run_en (state_q == RUN),
    .budget (s_data[RUN_CNT_W-1:0]),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    cpu_address_d   = cpu_address_q;
    cpu_inst_data_d = cpu_inst_data_q;
    wr_i_d          = wr_i_q;
    wr_d_d          = wr_d_q;
    done_d          = 1'b0;
    err_d           = err_q;
    addr_d          = addr_q;
    rem_d           = rem_q;
    tgt_data_d      = tgt_data_q;
    hold_d          = hold_q;
    timer_start     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op)
            OP_LOAD_I, OP_LOAD_D: begin
              if (cmd_cnt != '0) begin
                tgt_data_d = (op == OP_LOAD_D);
                addr_d     = s_data[BASE_LO +: ADDR_W];
                rem_d      = cmd_cnt;
                state_d    = LOAD;
              end
            end
            OP_RUN: begin
              timer_start = 1'b1;
              state_d     = RUN;
            end
            default: ;
          endcase
        end
      end
      LOAD: begin
        if (accept) begin
          cpu_address_d   = addr_q;
          cpu_inst_data_d = s_data;
          wr_i_d          = !tgt_data_q;
          wr_d_d          = tgt_data_q;
          hold_d          = '0;
          state_d         = WRITE;
        end
      end
      WRITE: begin
        if (hold_q == HOLD_W'(WR_HOLD - 1)) begin
          wr_i_d  = 1'b0;
          wr_d_d  = 1'b0;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? IDLE : LOAD;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        // Anything but HALT during a run is swallowed and flagged; the run keeps going.
        if (accept && op != OP_HALT) err_d = 1'b1;
        if ((accept && op == OP_HALT) || timer_expire) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d != WRITE);
    cpu_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_ready_q       <= 1'b0;
      cpu_rst_q       <= 1'b1;
      cpu_address_q   <= '0;
      cpu_inst_data_q <= '0;
      wr_i_q          <= 1'b0;
      wr_d_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      addr_q          <= '0;
      rem_q           <= '0;
      tgt_data_q      <= 1'b0;
      hold_q          <= '0;
    end else begin
      s_ready_q       <= s_ready_d;
      cpu_rst_q       <= cpu_rst_d;
      cpu_address_q   <= cpu_address_d;
      cpu_inst_data_q <= cpu_inst_data_d;
      wr_i_q          <= wr_i_d;
      wr_d_q          <= wr_d_d;
      done_q          <= done_d;
      err_q           <= err_d;
      addr_q          <= addr_d;
      rem_q           <= rem_d;
      tgt_data_q      <= tgt_data_d;
      hold_q          <= hold_d;
    end
  end

  assign s_ready               = s_ready_q;
  assign cpu_rst               = cpu_rst_q;
  assign cpu_address           = cpu_address_q;
  assign cpu_inst_data         = cpu_inst_data_q;
  assign cpu_write_instruction = wr_i_q;
  assign cpu_write_data        = wr_d_q;
  assign done                  = done_q;
  assign err                   = err_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Two loader instances (write hold 1 and 2) fed the same command stream, checked against a behavioural model.
module tb_cpu_program_loader;

  typedef struct packed {
    logic        is_d;
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  int vectors = 0;
  int miscompares = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] s_data = '0;
  logic [1:0]  s_valid_v = '0;
  logic [1:0]  s_ready_v;
  bit          end_chk = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int ln, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL lane%0d %s: got %0h required %0h", ln, name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int HOLD = g + 1;

    logic        cpu_rst_o, wi_o, wd_o, done_o, err_o;
    logic [9:0]  addr_o;
    logic [31:0] data_o;

    wr_t exp_wr[$];
    int  exp_run[$];
    logic exp_err, exp_done, exp_crst;

    cpu_program_loader #(
      .ADDR_W(10), .DATA_W(32), .WR_HOLD(HOLD), .RUN_CNT_W(24)
    ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .s_valid               (s_valid_v[g]),
      .s_ready               (s_ready_v[g]),
      .s_data                (s_data),
      .cpu_rst               (cpu_rst_o),
      .cpu_address           (addr_o),
      .cpu_inst_data         (data_o),
      .cpu_write_instruction (wi_o),
      .cpu_write_data        (wd_o),
      .done                  (done_o),
      .err                   (err_o)
    );

    // Reference model: mode 0 idle, 1 loading, 2 running.
    initial begin : model
      logic [31:0] w;
      logic [1:0]  op;
      logic [9:0]  m_addr;
      logic [23:0] m_budget;
      logic        m_tgt;
      int mode, m_rem, m_start, cyc;
      bit acc;
      wr_t e;
      mode = 0; m_rem = 0; m_start = 0; cyc = 0;
      m_addr = '0; m_budget = '0; m_tgt = 1'b0;
      exp_err = 1'b0; exp_done = 1'b0; exp_crst = 1'b1;
      forever begin
        @(posedge clk);
        cyc++;
        exp_done = 1'b0;
        acc = s_valid_v[g] && s_ready_v[g];
        w   = s_data;
        op  = w[31:30];
        if (!rst) begin
          mode = 0;
          exp_err = 1'b0;
          exp_run.delete();
        end else if (mode == 2) begin
          if (acc && op != 2'b11) exp_err = 1'b1;
          if ((acc && op == 2'b11) || (m_budget != 0 && cyc == m_start + int'(m_budget))) begin
            exp_done = 1'b1;
            exp_run.push_back(cyc - m_start);
            mode = 0;
          end
        end else if (acc) begin
          if (mode == 1) begin
            e.is_d = m_tgt; e.a = m_addr; e.d = w;
            exp_wr.push_back(e);
            m_addr = m_addr + 10'd1;
            m_rem--;
            if (m_rem == 0) mode = 0;
          end else if (op == 2'b10) begin
            m_budget = w[23:0];
            m_start  = cyc;
            mode     = 2;
          end else if (op != 2'b11 && w[25:16] != 0) begin
            m_tgt  = op[0];
            m_addr = w[9:0];
            m_rem  = int'(w[25:16]);
            mode   = 1;
          end
        end
        exp_crst = (mode != 2);
      end
    end

    initial begin : monitor
      wr_t e;
      int width, low;
      logic prev_s, prev_crst, s;
      width = 0; low = 0; prev_s = 1'b0; prev_crst = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
          chk("reset_state", g,
              {cpu_rst_o, s_ready_v[g], addr_o, data_o, wi_o, wd_o, done_o, err_o},
              {1'b1, 47'b0});
          width = 0; low = 0; prev_s = 1'b0; prev_crst = 1'b1;
        end else begin
          s = wi_o | wd_o;
          chk("cpu_rst", g, cpu_rst_o, exp_crst);
          chk("done", g, done_o, exp_done);
          chk("err", g, err_o, exp_err);
          if (s && !prev_s) begin
            if (exp_wr.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL lane%0d unexpected_write: got addr %0d data %h, required none", g, addr_o, data_o);
            end else begin
              e = exp_wr.pop_front();
              chk("wr_target", g, {wd_o, wi_o}, e.is_d ? 2'b10 : 2'b01);
              chk("wr_addr", g, addr_o, e.a);
              chk("wr_data", g, data_o, e.d);
              chk("ready_low_in_write", g, s_ready_v[g], 1'b0);
            end
            width = 1;
          end else if (s) begin
            width++;
          end
          if (!s && prev_s) chk("strobe_width", g, width, HOLD);
          if (!cpu_rst_o) low++;
          if (cpu_rst_o && !prev_crst) begin
            if (exp_run.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL lane%0d unexpected_run_end: got low for %0d cycles, required none", g, low);
            end else begin
              chk("run_len", g, low, exp_run.pop_front());
            end
            low = 0;
          end
          prev_s = s;
          prev_crst = cpu_rst_o;
        end
      end
    end

    initial begin : final_check
      wait (end_chk);
      chk("wr_queue_empty", g, exp_wr.size(), 0);
      chk("run_queue_empty", g, exp_run.size(), 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w);
    logic [1:0] acc;
    int guard;
    @(negedge clk);
    s_data = w;
    s_valid_v = 2'b11;
    guard = 0;
    while (s_valid_v != 2'b00 && guard < 200) begin
      acc = s_valid_v & s_ready_v;
      @(posedge clk);
      #1;
      s_valid_v = s_valid_v & ~acc;
      guard++;
      if (s_valid_v != 2'b00) @(negedge clk);
    end
    if (s_valid_v != 2'b00) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake_timeout: word %h still pending on lanes %b, required accept", w, s_valid_v);
      s_valid_v = 2'b00;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int k, cnt, base, b;
    logic [1:0] op;
    idle(3);
    rst = 1'b1;
    idle(2);

    send(32'h0003_0000);
    send(32'hA000_000A); send(32'hB000_000B); send(32'hC000_000C);
    idle(6);

    send(32'h4003_03FE);
    send(32'h1111_1111); send(32'h2222_2222); send(32'h3333_3333);
    idle(6);

    send(32'h8000_0014);
    idle(30);

    send(32'h8000_0000);
    idle(10);
    send(32'h0001_0000);
    idle(5);
    send(32'hC000_0000);
    idle(4);

    send(32'h0004_0000);
    send(32'hDEAD_BEEF);
    idle(4);
    rst = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);
    send(32'h0002_0005);
    send(32'h5555_0001); send(32'h5555_0002);
    idle(6);

    send(32'h0000_0000);
    send(32'hC000_0000);
    idle(2);
    chk("ready_idle", 0, s_ready_v, 2'b11);

    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 3);
      if (k <= 1) begin
        cnt  = $urandom_range(1, 5);
        base = $urandom_range(0, 1023);
        op   = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
        send({op, 4'b0, 10'(cnt), 6'b0, 10'(base)});
        for (int j = 0; j < cnt; j++) send($urandom);
        idle($urandom_range(0, 4));
      end else if (k == 2) begin
        b = $urandom_range(1, 25);
        send({2'b10, 6'b0, 24'(b)});
        idle($urandom_range(0, 30));
        if ($urandom_range(0, 1) == 1) send(32'hC000_0000);
        idle(3);
      end else begin
        send(32'h8000_0000);
        idle($urandom_range(1, 10));
        op = 2'($urandom_range(0, 2));
        send({op, 30'($urandom)});
        idle($urandom_range(0, 8));
        send(32'hC000_0000);
        idle(2);
      end
    end

    idle(40);
    end_chk = 1'b1;
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Host-side sequencer for the single-cycle CPU's load/run interface.
- Accepts a 32-bit command/data word stream (valid/ready) and drives the CPU load port: address, instruction/data word, and separate instruction-memory and data-memory write strobes.
- Holds the CPU in reset while loading, then releases it for a bounded or unbounded run and re-asserts reset on budget expiry or a HALT command.
- Sits between the host/test harness and the CPU top level.

Parameters:
- ADDR_W, 10, CPU memory address width. Addresses wrap modulo 2^ADDR_W.
- DATA_W, 32, instruction/data word width.
- WR_HOLD, 1, cycles each write strobe stays high. Legal values are 1 or more.
- RUN_CNT_W, 24, width of the run-cycle budget and counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts the word on this cycle.
- s_data  in  DATA_W  command or payload word.
- cpu_rst  out  1  active-high reset to the CPU; high in every state except RUN.
- cpu_address  out  ADDR_W  CPU memory write address.
- cpu_inst_data  out  DATA_W  word written to CPU instruction or data memory.
- cpu_write_instruction  out  1  instruction-memory write strobe.
- cpu_write_data  out  1  data-memory write strobe.
- done  out  1  one-cycle pulse when a run ends.
- err  out  1  sticky protocol error; cleared only by rst.

Behaviour:
- Handshake: a word transfers on a rising edge where s_valid and s_ready are both 1. All outputs are registered.
- Reset values (rst=0 at an edge): state=IDLE, cpu_rst=1, s_ready=0, cpu_address=0, cpu_inst_data=0, both strobes 0, done=0, err=0, counters 0. s_ready rises the cycle after rst returns to 1.
- Reset mid-operation discards any partial load or run with no further strobes.
- Command decode, s_data[31:30]: 00 LOAD_I, 01 LOAD_D, 10 RUN, 11 HALT.
- LOAD fields: count=[25:16] (words), base=[9:0].
- RUN fields: budget=[RUN_CNT_W-1:0].

States:
- IDLE: s_ready=1.
  - LOAD_I/LOAD_D with count>0: latch target, addr=base, remaining=count, go to LOAD.
  - LOAD_I/LOAD_D with count=0: no-op, stay in IDLE.
  - RUN: latch budget, go to RUN; cpu_rst=0 from the next cycle.
  - HALT: no-op.
- LOAD: s_ready=1. On handshake, the next cycle drives cpu_address=addr, cpu_inst_data=s_data, and the target strobe=1 (only one strobe is ever high). Go to WRITE.
- WRITE: s_ready=0; strobe held WR_HOLD cycles. On the last cycle: strobe=0, addr=addr+1 mod 2^ADDR_W, remaining-1. Go to IDLE when remaining reaches 0, else back to LOAD.
  - Throughput: one word per WR_HOLD+1 cycles.
  - Latency: a word accepted at edge N has its strobe high for cycles N+1..N+WR_HOLD.
- RUN: s_ready=1; cpu_rst=0; run counter increments each cycle.
  - budget>0 and counter==budget: cpu_rst=1, done pulse, go to IDLE. cpu_rst is low for exactly budget cycles.
  - budget=0: unlimited run.
  - HALT accepted: cpu_rst=1 and done pulse the next cycle, go to IDLE.
  - LOAD_I/LOAD_D/RUN accepted in RUN: word consumed and ignored, err=1, run continues.
  - HALT on the same cycle the budget expires: a single done pulse, go to IDLE.
- cpu_address and cpu_inst_data hold their last values when no strobe is active.

Decomposition:
- Shared package cpu_loader_pkg: opcode constants, command field bit positions, state enum (IDLE, LOAD, WRITE, RUN).
- One natural sub-module, loader_run_timer: budget latch, counter, and expiry flag.
- Everything else stays in cpu_program_loader.

Test Plan:
- Load 3 instructions: send 0x00030000, then words A, B, C -> cpu_write_instruction pulses at addresses 0, 1, 2 with A, B, C; cpu_write_data stays 0; cpu_rst stays 1; state returns to IDLE.
- Data load with wrap: send 0x400303FE, then 3 words -> cpu_write_data pulses at addresses 1022, 1023, 0. Repeat with WR_HOLD=2 -> each strobe high 2 cycles and s_ready low for those 2 cycles.
- Bounded run: send 0x80000014 -> cpu_rst low for exactly 20 cycles starting the cycle after acceptance, then high; done pulses once.
- Unbounded run with error: send 0x80000000, then 0x00010000 after 10 cycles -> err=1, no strobes, cpu_rst stays 0. Then send 0xC0000000 -> cpu_rst=1 and done pulses the next cycle.
- Reset mid-load: send 0x00040000, then 1 word, then pull rst=0 -> all outputs at reset values, no further strobes. A fresh load at base 5 writes correctly from address 5.
- Zero count and stray HALT: send 0x00000000 and 0xC0000000 in IDLE -> no strobes, no done pulse, err=0, s_ready stays 1.
